// File: rtl/magnitude_window_stats_if.sv
// Sample stream in, windowed peak/average result out, plus status flags.
// slave is the statistics block's view; master is the driving environment's view.
interface magnitude_window_stats_if;
    logic [7:0] mag_in;
    logic       mag_valid;
    logic       mag_ready;
    logic       clear;
    logic [7:0] out_peak;
    logic [7:0] out_avg;
    logic       out_valid;
    logic       out_ready;
    logic       alarm;
    logic       overrun;

    modport slave (
        input  mag_in, mag_valid, clear, out_ready,
        output mag_ready, out_peak, out_avg, out_valid, alarm, overrun
    );

    modport master (
        output mag_in, mag_valid, clear, out_ready,
        input  mag_ready, out_peak, out_avg, out_valid, alarm, overrun
    );
endinterface

// File: rtl/magnitude_window_stats.sv
// Peak/mean over fixed 2^WIN_LOG2-sample windows with hysteresis alarm; result one cycle after last accept.
// Intake stalls (mag_ready=0) while a result is held; samples offered then set the sticky overrun flag.
module magnitude_window_stats #(
    parameter int unsigned WIN_LOG2  = 3,
    parameter logic [7:0]  THRESH_HI = 8'd100,
    parameter logic [7:0]  THRESH_LO = 8'd80
) (
    input  logic                           clk,
    input  logic                           rst_n,
    magnitude_window_stats_if.slave        bus
);
    localparam int unsigned SUM_W = 8 + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d, sum_acc;
    logic [7:0]          peak_q, peak_d, peak_acc;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [7:0]          out_peak_q, out_peak_d;
    logic [7:0]          out_avg_q, out_avg_d;
    logic [7:0]          avg_new;
    logic                out_valid_q, out_valid_d;
    logic                alarm_q, alarm_d;
    logic                overrun_q, overrun_d;
    logic                accept;

    assign accept   = bus.mag_valid && (state_q == ACCUM) && !bus.clear;
    assign sum_acc  = sum_q + SUM_W'(bus.mag_in);
    assign peak_acc = (bus.mag_in > peak_q) ? bus.mag_in : peak_q;
    assign avg_new  = sum_acc[SUM_W-1:WIN_LOG2];

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        peak_d      = peak_q;
        cnt_d       = cnt_q;
        out_peak_d  = out_peak_q;
        out_avg_d   = out_avg_q;
        out_valid_d = out_valid_q;
        alarm_d     = alarm_q;
        overrun_d   = overrun_q;

        if (bus.clear) begin
            // clear wins over any sample, handshake or overrun in the same cycle
            state_d     = ACCUM;
            sum_d       = '0;
            peak_d      = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            alarm_d     = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (bus.mag_valid && (state_q == HOLD)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        sum_d  = sum_acc;
                        peak_d = peak_acc;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d     = HOLD;
                            out_peak_d  = peak_acc;
                            out_avg_d   = avg_new;
                            out_valid_d = 1'b1;
                            if (avg_new >= THRESH_HI) begin
                                alarm_d = 1'b1;
                            end else if (avg_new <= THRESH_LO) begin
                                alarm_d = 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                        sum_d       = '0;
                        peak_d      = '0;
                        cnt_d       = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            peak_q      <= '0;
            cnt_q       <= '0;
            out_peak_q  <= '0;
            out_avg_q   <= '0;
            out_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            peak_q      <= peak_d;
            cnt_q       <= cnt_d;
            out_peak_q  <= out_peak_d;
            out_avg_q   <= out_avg_d;
            out_valid_q <= out_valid_d;
            alarm_q     <= alarm_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.mag_ready = (state_q == ACCUM);
    assign bus.out_peak  = out_peak_q;
    assign bus.out_avg   = out_avg_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alarm     = alarm_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_magnitude_window_stats.sv
// Randomized and directed stimulus for magnitude_window_stats, checked against a window-queue model.
module tb_magnitude_window_stats;
    localparam int WL    = 3;
    localparam int N     = 1 << WL;
    localparam int TH_HI = 100;
    localparam int TH_LO = 80;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    magnitude_window_stats_if bus();

    magnitude_window_stats #(
        .WIN_LOG2 (WL),
        .THRESH_HI(8'(TH_HI)),
        .THRESH_LO(8'(TH_LO))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a queue of the samples in the current window.
    int win[$];
    bit m_hold;
    int m_peak, m_avg;
    bit m_valid, m_alarm, m_overrun;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        win.delete();
        m_hold = 0; m_peak = 0; m_avg = 0;
        m_valid = 0; m_alarm = 0; m_overrun = 0;
    endtask

    task automatic model_step();
        int s, mx;
        if (!rst_n) begin
            reset_model();
        end else if (bus.clear) begin
            win.delete();
            m_hold = 0; m_valid = 0; m_alarm = 0; m_overrun = 0;
        end else begin
            if (bus.mag_valid && m_hold) m_overrun = 1;
            if (!m_hold && bus.mag_valid) begin
                win.push_back(int'(bus.mag_in));
                if (win.size() == N) begin
                    s = 0; mx = 0;
                    foreach (win[i]) begin
                        s += win[i];
                        if (win[i] > mx) mx = win[i];
                    end
                    m_peak = mx;
                    m_avg  = s / N;
                    if (m_avg >= TH_HI) m_alarm = 1;
                    else if (m_avg <= TH_LO) m_alarm = 0;
                    m_hold = 1; m_valid = 1;
                    win.delete();
                end
            end else if (m_hold && bus.out_ready) begin
                m_hold = 0; m_valid = 0;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, " mag_ready"}, 32'(bus.mag_ready), 32'(!m_hold));
        check({ctx, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({ctx, " out_peak"},  32'(bus.out_peak),  32'(m_peak));
        check({ctx, " out_avg"},   32'(bus.out_avg),   32'(m_avg));
        check({ctx, " alarm"},     32'(bus.alarm),     32'(m_alarm));
        check({ctx, " overrun"},   32'(bus.overrun),   32'(m_overrun));
    endtask

    task automatic drive(input bit v, input int m, input bit clr, input bit ordy);
        bus.mag_valid = v;
        bus.mag_in    = 8'(m);
        bus.clear     = clr;
        bus.out_ready = ordy;
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_step();
        #1;
        compare_all(ctx);
    endtask

    // Full window of a constant value, result checked, then drained.
    task automatic window(input int v, input int exp_alarm, input string ctx);
        for (int i = 0; i < N; i++) begin
            drive(1, v, 0, 1);
            step(ctx);
        end
        check({ctx, " const avg"},   32'(bus.out_avg),  32'(v));
        check({ctx, " const peak"},  32'(bus.out_peak), 32'(v));
        check({ctx, " const alarm"}, 32'(bus.alarm),    32'(exp_alarm));
        drive(0, 0, 0, 1);
        step({ctx, " drain"});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        reset_model();

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), $urandom_range(255), 1'($urandom), 1'($urandom));
            step("reset");
            check("reset mag_ready const", 32'(bus.mag_ready), 32'd1);
        end
        #3 rst_n = 1'b1;
        drive(0, 0, 0, 0);
        step("release");

        // 10..80 back to back
        for (int i = 1; i <= N; i++) begin
            drive(1, i * 10, 0, 1);
            step("ramp");
        end
        check("ramp avg",   32'(bus.out_avg),   32'd45);
        check("ramp peak",  32'(bus.out_peak),  32'd80);
        check("ramp alarm", 32'(bus.alarm),     32'd0);
        check("ramp valid", 32'(bus.out_valid), 32'd1);
        drive(0, 0, 0, 1);
        step("ramp drain");
        check("ramp ready after", 32'(bus.mag_ready), 32'd1);

        // Hysteresis
        window(255, 1, "w255");
        window(90, 1, "w90");
        window(80, 0, "w80");

        // Stall in HOLD with samples offered
        for (int i = 0; i < N; i++) begin
            drive(1, 5, 0, 0);
            step("stall fill");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 33, 0, 0);
            step("stall");
        end
        check("stall ready",   32'(bus.mag_ready), 32'd0);
        check("stall overrun", 32'(bus.overrun),   32'd1);
        drive(0, 0, 0, 1);
        step("stall release");
        for (int i = 1; i <= N; i++) begin
            drive(1, i, 0, 1);
            step("fresh");
        end
        check("fresh avg",     32'(bus.out_avg), 32'd4);
        check("fresh overrun", 32'(bus.overrun), 32'd1);
        drive(0, 0, 0, 1);
        step("fresh drain");

        // Clear mid-window discards partial sum
        for (int i = 0; i < 3; i++) begin
            drive(1, 200, 0, 1);
            step("pre clear");
        end
        drive(1, 200, 1, 1);
        step("clear");
        check("clear overrun", 32'(bus.overrun), 32'd0);
        window(7, 0, "w7");

        // Asynchronous reset while holding a result
        for (int i = 0; i < N; i++) begin
            drive(1, 255, 0, 0);
            step("pre areset");
        end
        #2 rst_n = 1'b0;
        reset_model();
        #1;
        compare_all("areset");
        check("areset valid const", 32'(bus.out_valid), 32'd0);
        check("areset ready const", 32'(bus.mag_ready), 32'd1);
        #2 rst_n = 1'b1;
        drive(0, 0, 0, 0);
        step("areset release");
        window(50, 0, "w50");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int m;
            m = ($urandom_range(1) == 1) ? $urandom_range(255) : $urandom_range(110, 70);
            drive($urandom_range(9) < 7, m, $urandom_range(99) < 2, $urandom_range(9) < 6);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/magnitude_window_stats.md
MAGNITUDE_WINDOW_STATS -- requirements
Module: magnitude_window_stats

Interface
REQ-001 Parameter WIN_LOG2, default 3, log2 of samples per window (window length N = 2^WIN_LOG2, legal 1..6).
REQ-002 Parameter THRESH_HI, default 8'd100, alarm set level.
REQ-003 Parameter THRESH_LO, default 8'd80, alarm clear level; THRESH_LO <= THRESH_HI.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mag_in  input  8  unsigned magnitude sample from the upstream sqrt(a^2+b^2) stage.
REQ-007 mag_valid  input  1  mag_in is valid this cycle.
REQ-008 mag_ready  output  1  block accepts a sample this cycle.
REQ-009 clear  input  1  synchronous window/flag clear.
REQ-010 out_peak  output  8  maximum sample of the completed window.
REQ-011 out_avg  output  8  mean of the completed window.
REQ-012 out_valid  output  1  out_peak/out_avg are valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 alarm  output  1  hysteresis threshold flag on window average.
REQ-015 overrun  output  1  sticky flag: sample offered while not accepted.

Function
REQ-016 The block SHALL have two states, ACCUM and HOLD; mag_ready SHALL equal 1 exactly when in ACCUM.
REQ-017 A sample SHALL be accepted on a rising edge where mag_valid && mag_ready && !clear.
REQ-018 In ACCUM, each accepted sample SHALL add to an unsigned sum of width 8+WIN_LOG2 (no overflow possible), update the running peak as max(peak, mag_in), and increment a sample counter.
REQ-019 On the edge accepting the N-th sample, the block SHALL enter HOLD, register out_peak = peak including that sample, out_avg = final sum >> WIN_LOG2 (truncating), and set out_valid = 1 from the next cycle.
REQ-020 In HOLD, out_peak, out_avg, out_valid SHALL remain stable until the edge where out_valid && out_ready.
REQ-021 On that handshake edge, the block SHALL clear out_valid, zero sum/peak/counter and return to ACCUM (mag_ready = 1 next cycle); out_peak/out_avg retain their last values.
REQ-022 alarm SHALL update only on the edge entering HOLD: set if the new average >= THRESH_HI, cleared if <= THRESH_LO, otherwise unchanged.
REQ-023 overrun SHALL set on any edge where mag_valid && !mag_ready and remain set until clear or reset.
REQ-024 clear SHALL take priority over all other events in the same cycle: next state ACCUM, sum/peak/counter = 0, out_valid = 0, alarm = 0, overrun = 0, any concurrent sample discarded and no handshake counted.
REQ-025 A sample of value 0 SHALL count toward the window like any other value.

Reset
REQ-026 While rst_n = 0, the block SHALL be in ACCUM with sum, peak, counter, out_peak, out_avg, out_valid, alarm, overrun all 0, independent of clk.
REQ-027 Reset asserted mid-window or in HOLD SHALL discard all partial and pending results immediately.
REQ-028 After rst_n deasserts, mag_ready SHALL be 1 and the first accepted sample SHALL start a fresh window.

Verification
REQ-029 Reset: hold rst_n = 0 with random inputs -> all outputs 0 except mag_ready = 1; release -> mag_ready = 1, out_valid = 0.
REQ-030 Samples 10,20,...,80 back-to-back, out_ready = 1 -> out_valid high one cycle after 8th accept, out_peak = 80, out_avg = 45, alarm = 0, then mag_ready = 1 the following cycle.
REQ-031 Windows of all-255, then all-90, then all-80 -> avg 255 with alarm = 1; avg 90 alarm stays 1; avg 80 alarm = 0; peak 255/90/80.
REQ-032 Complete window, hold out_ready = 0 for 5 cycles with mag_valid = 1 -> mag_ready = 0, outputs stable, overrun = 1; then out_ready = 1 -> next window starts with zeroed sum, overrun remains 1.
REQ-033 Accept 3 samples of 200, then clear = 1 with mag_valid = 1 -> sample discarded, overrun = 0; next eight samples of 7 -> out_avg = 7, out_peak = 7.
REQ-034 rst_n pulsed low asynchronously (between clock edges) while in HOLD -> out_valid, out_peak, out_avg, alarm drop to 0 immediately; mag_ready = 1.
